// File: rtl/vga_timing_pipe.sv
// vga_timing_pipe
// ---------------
// VGA raster timing generator with a pixel-request interface and a
// latency-matched sync/display-enable pipeline.
//
// A horizontal counter (hcnt) and a vertical counter (vcnt) walk the raster.
// Each line is ordered sync, back porch, active, front porch, and so is each frame.
// Whenever the counters sit in the active area, pix_req is raised together with
// the (x,y) coordinate. The external source answers with `pixel` PIX_LAT enabled
// cycles later. The raw hs/vs/active flags are delayed by the same number of
// enabled cycles, so hs, vs, de and rgb line up with the returned pixel.
//
// Ports
//   clk          pixel-domain clock, rising edge
//   rstn         asynchronous active-low reset
//   en           pixel clock enable; nothing advances while en=0
//   pixel        colour from the source, PIX_LAT enabled cycles after request
//   pix_req      counters are in the active area (combinational)
//   pix_x/pix_y  requested coordinate, all-ones when pix_req=0
//   hs/vs/de     delayed sync and display enable, aligned with pixel
//   rgb          pixel when de=1, else 0
//   line_start   en=1 and hcnt=0 (request-aligned pulse)
//   frame_start  en=1, hcnt=0 and vcnt=0
module vga_timing_pipe #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b1,
  parameter int PIX_LAT  = 2,
  parameter int RGB_W    = 12,
  parameter int CNT_W    = 11
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic [RGB_W-1:0] pixel,
  output logic             pix_req,
  output logic [CNT_W-1:0] pix_x,
  output logic [CNT_W-1:0] pix_y,
  output logic             hs,
  output logic             vs,
  output logic             de,
  output logic [RGB_W-1:0] rgb,
  output logic             line_start,
  output logic             frame_start
);

  localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;

  // Parameter sanity: refuse to elaborate an impossible configuration.
  if (CNT_W < 1 || CNT_W > 31) begin : g_bad_cnt_w
    $error("vga_timing_pipe: CNT_W must be 1..31");
  end
  if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
      V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_timing
    $error("vga_timing_pipe: every timing parameter must be >= 1");
  end
  if (longint'(H_TOTAL - 1) >= (64'sd1 <<< CNT_W) ||
      longint'(V_TOTAL - 1) >= (64'sd1 <<< CNT_W)) begin : g_bad_total
    $error("vga_timing_pipe: H_TOTAL-1 / V_TOTAL-1 do not fit in CNT_W bits");
  end
  if (PIX_LAT < 0 || PIX_LAT > 7) begin : g_bad_lat
    $error("vga_timing_pipe: PIX_LAT must be 0..7");
  end

  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_SY   = CNT_W'(H_SYNC);
  localparam logic [CNT_W-1:0] V_SY   = CNT_W'(V_SYNC);
  localparam logic [CNT_W-1:0] H_ST   = CNT_W'(H_SYNC + H_BP);
  localparam logic [CNT_W-1:0] H_EN   = CNT_W'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ST   = CNT_W'(V_SYNC + V_BP);
  localparam logic [CNT_W-1:0] V_EN   = CNT_W'(V_SYNC + V_BP + V_ACTIVE);

  logic [CNT_W-1:0] hcnt;
  logic [CNT_W-1:0] vcnt;
  logic             hs_raw;
  logic             vs_raw;
  logic             hs_d;
  logic             vs_d;
  logic             de_d;

  // ---- stage p0: raster counters ----
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (en) begin
      if (hcnt == H_LAST) begin
        hcnt <= '0;
        vcnt <= (vcnt == V_LAST) ? '0 : vcnt + ONE;
      end else begin
        hcnt <= hcnt + ONE;
      end
    end
  end

  always_comb begin
    pix_req = (hcnt >= H_ST) && (hcnt < H_EN) && (vcnt >= V_ST) && (vcnt < V_EN);
    pix_x   = pix_req ? hcnt - H_ST : '1;
    pix_y   = pix_req ? vcnt - V_ST : '1;
    hs_raw  = (hcnt < H_SY) ? SYNC_POL : ~SYNC_POL;
    vs_raw  = (vcnt < V_SY) ? SYNC_POL : ~SYNC_POL;
  end

  // ---- stages p1..pPIX_LAT: latency-matching delay line ----
  if (PIX_LAT == 0) begin : g_lat0
    assign hs_d = hs_raw;
    assign vs_d = vs_raw;
    assign de_d = pix_req;
  end else begin : g_lat
    logic [PIX_LAT-1:0] hs_p;
    logic [PIX_LAT-1:0] vs_p;
    logic [PIX_LAT-1:0] de_p;

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        hs_p <= {PIX_LAT{~SYNC_POL}};
        vs_p <= {PIX_LAT{~SYNC_POL}};
        de_p <= '0;
      end else if (en) begin
        hs_p[0] <= hs_raw;
        vs_p[0] <= vs_raw;
        de_p[0] <= pix_req;
        for (int i = 1; i < PIX_LAT; i++) begin
          hs_p[i] <= hs_p[i-1];
          vs_p[i] <= vs_p[i-1];
          de_p[i] <= de_p[i-1];
        end
      end
    end

    assign hs_d = hs_p[PIX_LAT-1];
    assign vs_d = vs_p[PIX_LAT-1];
    assign de_d = de_p[PIX_LAT-1];
  end

  // ---- output stage ----
  // Outputs are forced to their idle levels while rstn is low. Without this, the
  // zero-latency build would show an asserted hs/vs (the counters rest at 0,
  // inside the sync pulse). It would also show a line_start pulse during reset.
  always_comb begin
    hs          = rstn ? hs_d : ~SYNC_POL;
    vs          = rstn ? vs_d : ~SYNC_POL;
    de          = rstn & de_d;
    rgb         = de ? pixel : '0;
    line_start  = rstn & en & (hcnt == '0);
    frame_start = line_start & (vcnt == '0);
  end

endmodule

// File: doc/vga_timing_pipe.md
VGA_TIMING_PIPE -- requirements
Module: vga_timing_pipe

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 SHALL have parameters H_FP 16, H_SYNC 96, H_BP 48, giving horizontal front porch, sync and back porch in pixels.
REQ-003 SHALL have parameters V_ACTIVE 480, V_FP 10, V_SYNC 2, V_BP 33, giving vertical timing in lines.
REQ-004 SHALL have parameter SYNC_POL, default 1: asserted level of hs/vs (1 = active-high).
REQ-005 SHALL have parameter PIX_LAT, default 2, range 0..7: enabled cycles from pixel request to pixel data valid.
REQ-006 SHALL have parameters RGB_W 12 (colour width) and CNT_W 11 (counter/coordinate width).
REQ-007 clk  input  1  pixel-domain clock; all state on rising edge.
REQ-008 rstn  input  1  asynchronous, active-low reset.
REQ-009 en  input  1  pixel clock enable; state advances only when en=1.
REQ-010 pixel  input  RGB_W  colour from source, valid PIX_LAT enabled cycles after its request.
REQ-011 pix_req  output  1  current counter position is in the active area.
REQ-012 pix_x, pix_y  output  CNT_W each  requested coordinate; all-ones when pix_req=0.
REQ-013 hs, vs, de  output  1 each  sync and display-enable, delayed to align with pixel.
REQ-014 rgb  output  RGB_W  pixel when de=1, else 0.
REQ-015 line_start, frame_start  output  1 each  single-cycle pulses, request-aligned.

Function
REQ-016 H_TOTAL = H_SYNC+H_BP+H_ACTIVE+H_FP; V_TOTAL likewise; line order is sync, back porch, active, front porch.
REQ-017 hcnt SHALL count 0..H_TOTAL-1 on en=1 and wrap to 0; vcnt SHALL increment only on the en=1 cycle where hcnt wraps, counting 0..V_TOTAL-1 and wrapping to 0.
REQ-018 With en=0, counters, delay lines and all registered outputs SHALL hold.
REQ-019 pix_req SHALL be combinational: 1 iff H_SYNC+H_BP <= hcnt < H_SYNC+H_BP+H_ACTIVE and V_SYNC+V_BP <= vcnt < V_SYNC+V_BP+V_ACTIVE.
REQ-020 When pix_req=1, pix_x = hcnt-(H_SYNC+H_BP) and pix_y = vcnt-(V_SYNC+V_BP); otherwise both all-ones.
REQ-021 Raw hs SHALL be asserted iff hcnt < H_SYNC; raw vs iff vcnt < V_SYNC; asserted level = SYNC_POL.
REQ-022 Raw hs, vs and pix_req SHALL pass through a PIX_LAT-stage shift register advancing only on en=1; stage outputs drive hs, vs, de.
REQ-023 PIX_LAT=0 SHALL yield combinational pass-through (de = pix_req, same cycle).
REQ-024 rgb SHALL equal pixel when de=1 and 0 otherwise, combinationally.
REQ-025 line_start SHALL be 1 iff en=1 and hcnt=0; frame_start iff en=1, hcnt=0 and vcnt=0; both assert together at frame start.
REQ-026 H_TOTAL-1 and V_TOTAL-1 SHALL fit in CNT_W bits, PIX_LAT SHALL be 0..7, and all timing parameters SHALL be >=1; violation SHALL be an elaboration error.

Reset
REQ-027 rstn=0 SHALL asynchronously clear hcnt, vcnt and delay lines; delay-line sync stages clear to deasserted level (!SYNC_POL), de stages to 0.
REQ-028 During reset: hs=vs=!SYNC_POL, de=0, rgb=0, line_start=frame_start=0.
REQ-029 Reset mid-frame SHALL discard in-flight delay-line contents; after release the first en=1 cycle is hcnt=0, vcnt=0 with frame_start=1.

Verification
REQ-030 Defaults, en=1 after reset: hs=1 for hcnt 0..95 delayed 2 cycles; first pix_req at hcnt=144, vcnt=35 with pix_x=0, pix_y=0; line = 800 cycles, frame = 420000 cycles.
REQ-031 en toggling 1/0: each line = 800 enabled cycles, outputs constant across en=0 cycles, de still aligned with 2-enabled-cycle latency model.
REQ-032 Source model returning pixel={pix_y[3:0],pix_x[7:0]} after PIX_LAT=2: rgb matches coordinate for all 640x480 de cycles, rgb=0 elsewhere.
REQ-033 At hcnt=799, vcnt=524 with en=1: next cycle hcnt=0, vcnt=0, line_start=frame_start=1 same cycle; at hcnt=0, vcnt=1 only line_start=1.
REQ-034 rstn pulsed low at hcnt=400, vcnt=100: hs=vs=0, de=0, rgb=0 immediately without clock; after release timing restarts per REQ-029.
REQ-035 Instance SYNC_POL=0, PIX_LAT=0: hs=0 for hcnt<96, de equals pix_req in the same cycle, reset hs=vs=1.
